// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: ALU op sequencer; single-cycle logic/arith/compare, iterative STEP-bit shifts.
module alu_seq_ctrl #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2;
  localparam logic [SW:0] STEP_W = (SW+1)'(STEP);
  logic [1:0]      r_state;
  logic [XLEN-1:0] r_acc;
  logic [SW:0]     r_cnt;
  logic [1:0]      r_kind;
  logic            r_illegal;
  logic [XLEN-1:0] w_alu;
  logic            w_ill;
  logic            w_is_shift;
  logic [SW:0]     w_shamt;
  logic [SW:0]     w_k;
  logic [XLEN-1:0] w_shifted;
  logic            w_accept;
  assign in_ready    = r_state == S_IDLE;
  assign out_valid   = r_state == S_DONE;
  assign busy        = r_state != S_IDLE;
  assign out_result  = r_acc;
  assign out_illegal = r_illegal;
  assign w_accept    = in_valid & in_ready & ~flush;
  assign w_shamt     = {1'b0, in_b[SW-1:0]};
  assign w_is_shift  = in_op == 4'b0111 || in_op == 4'b1000 || in_op == 4'b1001;
  assign w_k         = r_cnt < STEP_W ? r_cnt : STEP_W;
  // r_kind: 0 SLL, 1 SRL, 2 SRA; SRA keeps the original sign since acc's MSB never changes
  assign w_shifted   = r_kind == 2'd0 ? r_acc << w_k :
                       r_kind == 2'd1 ? r_acc >> w_k :
                       XLEN'($signed(r_acc) >>> w_k);
  always_comb begin
    w_alu = '0;
    w_ill = 1'b0;
    case (in_op)
      4'b0000: w_alu = in_a + in_b;
      4'b0001: w_alu = in_a - in_b;
      4'b0010: w_alu = in_a ^ in_b;
      4'b0011: w_alu = in_a | in_b;
      4'b0100: w_alu = in_a & in_b;
      4'b0101: w_alu = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      4'b0110: w_alu = {{(XLEN-1){1'b0}}, in_a < in_b};
      4'b0111, 4'b1000, 4'b1001, 4'b1111: w_alu = in_a;
      default: w_ill = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_kind    <= 2'd0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_acc     <= w_alu;
          r_illegal <= w_ill;
          r_kind    <= in_op == 4'b0111 ? 2'd0 : in_op == 4'b1000 ? 2'd1 : 2'd2;
          r_cnt     <= w_is_shift ? w_shamt : '0;
          r_state   <= w_is_shift && w_shamt != '0 ? S_SHIFT : S_DONE;
        end
        S_SHIFT: begin
          r_acc <= w_shifted;
          r_cnt <= r_cnt - w_k;
          if (r_cnt == w_k) r_state <= S_DONE;
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed and random op sequences checked against a behavioural ALU model.
module tb_alu_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_illegal, busy;
  logic [31:0] out_result;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  alu_seq_ctrl #(.XLEN(32), .STEP(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_illegal(out_illegal), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic ill, output int lat);
    int sh = int'(b[4:0]);
    ill = 1'b0;
    lat = 1;
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a ^ b;
      4'd3: res = a | b;
      4'd4: res = a & b;
      4'd5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: res = (a < b) ? 32'd1 : 32'd0;
      4'd7: begin res = a << sh; lat = 1 + sh; end
      4'd8: begin res = a >> sh; lat = 1 + sh; end
      4'd9: begin res = $signed(a) >>> sh; lat = 1 + sh; end
      4'd15: res = a;
      default: begin res = 32'd0; ill = 1'b1; end
    endcase
  endfunction
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int bp);
    logic [31:0] er;
    logic ei;
    int el, lat;
    model(op, a, b, er, ei, el);
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = $urandom; in_a = $urandom; in_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 64) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) chk({tag, "_busy"}, {30'd0, busy, in_ready}, 32'd2);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, el);
    chk({tag, "_result"}, out_result, er);
    chk({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, ei});
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk({tag, "_bp_state"}, {29'd0, out_valid, in_ready, busy}, 32'd5);
      chk({tag, "_bp_result"}, out_result, er);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "_release"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
  endtask
  initial begin
    #12;
    chk("reset", {28'd0, out_valid, out_illegal, busy, in_ready}, 32'd1);
    chk("reset_result", out_result, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op("add", 4'd0, 32'd5, 32'd7, 0);
    run_op("sra4", 4'd9, 32'h8000_0000, 32'd4, 0);
    run_op("sll_mask", 4'd7, 32'd1, 32'h20, 0);
    run_op("sll31", 4'd7, 32'd1, 32'd31, 0);
    run_op("sra31", 4'd9, 32'h8000_1234, 32'd31, 0);
    run_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sub", 4'd1, 32'd0, 32'd1, 0);
    run_op("bp_xor", 4'd2, 32'hF0F0_1234, 32'h0FF0_4321, 3);
    run_op("illegal", 4'd10, 32'h1234_5678, 32'd9, 0);
    run_op("pass", 4'd15, 32'hDEAD_BEEF, 32'd3, 0);
    // flush on the third SHIFT cycle of SRL by 10
    @(negedge clk); in_valid = 1'b1; in_op = 4'd8; in_a = 32'hFFFF_0000; in_b = 32'd10;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_idle", {29'd0, out_valid, in_ready, busy}, 32'd2);
    begin
      int seen = 0;
      for (int i = 0; i < 15; i++) begin @(posedge clk); #1; seen += int'(out_valid); end
      chk("flush_no_valid", seen, 0);
    end
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_op = 4'd0;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    chk("flush_no_accept", {29'd0, out_valid, in_ready, busy}, 32'd2);
    // async reset in the middle of a shift
    @(negedge clk); in_valid = 1'b1; in_op = 4'd7; in_a = 32'd3; in_b = 32'd20;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #2; rst = 1'b1; #1;
    chk("async_rst", {28'd0, out_valid, out_illegal, busy, in_ready}, 32'd1);
    chk("async_rst_result", out_result, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      run_op("rand", op, $urandom, $urandom, int'($urandom_range(0, 2)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
